// File: rtl/regfile_ckpt.sv
// Architectural register file with rename-status table and branch checkpoints.
// The live busy/tag table is snapshotted into NCKPT slots on a save. A
// restore reloads it in one cycle, and flush_all clears all rename state.
// Reads are combinational and forward a same-cycle commit on a tag match.

// One combinational read port: x0, then the commit bypass, then stored state.
module regfile_ckpt_rdport #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int REG_AW = 5,
  parameter int ROB_AW = 4
) (
  input  logic [REG_AW-1:0]             i_addr,
  input  logic [NREG-1:0]               i_busy,
  input  logic [NREG-1:0][ROB_AW-1:0]   i_tag,
  input  logic [NREG-1:0][DATA_W-1:0]   i_val,
  input  logic                          i_commit,
  input  logic [REG_AW-1:0]             i_commit_rd,
  input  logic [DATA_W-1:0]             i_commit_val,
  input  logic [ROB_AW-1:0]             i_commit_tag,
  output logic                          o_busy,
  output logic [DATA_W-1:0]             o_val,
  output logic [ROB_AW-1:0]             o_tag
);

  logic w_hit;

  // The bypass applies only when the commit actually retires the live producer.
  assign w_hit = i_commit && (i_commit_rd != '0) && (i_addr == i_commit_rd) &&
                 i_busy[i_commit_rd] && (i_tag[i_commit_rd] == i_commit_tag);

  // Select between hardwired zero, the forwarded commit and the stored entry.
  always_comb begin
    o_busy = 1'b0;
    o_val  = '0;
    o_tag  = '0;
    if (i_addr == '0) begin
      o_busy = 1'b0;
    end else if (w_hit) begin
      o_val  = i_commit_val;
    end else begin
      o_busy = i_busy[i_addr];
      o_val  = i_val[i_addr];
      o_tag  = i_tag[i_addr];
    end
  end

endmodule

module regfile_ckpt #(
  parameter int DATA_W  = 32,
  parameter int NREG    = 32,
  parameter int REG_AW  = 5,
  parameter int ROB_AW  = 4,
  parameter int NRP     = 2,
  parameter int NCKPT   = 4,
  parameter int CKPT_AW = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_rdy,
  // read ports
  input  logic [NRP*REG_AW-1:0]   i_rd_addr,
  output logic [NRP-1:0]          o_rd_busy,
  output logic [NRP*DATA_W-1:0]   o_rd_val,
  output logic [NRP*ROB_AW-1:0]   o_rd_tag,
  // issue / rename
  input  logic                    i_issue,
  input  logic [REG_AW-1:0]       i_issue_rd,
  input  logic [ROB_AW-1:0]       i_issue_tag,
  // commit
  input  logic                    i_commit,
  input  logic [REG_AW-1:0]       i_commit_rd,
  input  logic [DATA_W-1:0]       i_commit_val,
  input  logic [ROB_AW-1:0]       i_commit_tag,
  // checkpoints
  input  logic                    i_ckpt_save,
  input  logic [CKPT_AW-1:0]      i_ckpt_save_id,
  input  logic                    i_ckpt_restore,
  input  logic [CKPT_AW-1:0]      i_ckpt_restore_id,
  input  logic                    i_flush_all
);

  // architectural values and live rename table
  logic [NREG-1:0][DATA_W-1:0]              r_val;
  logic [NREG-1:0]                          r_busy;
  logic [NREG-1:0][ROB_AW-1:0]              r_tag;
  // checkpoint images of the rename table
  logic [NCKPT-1:0][NREG-1:0]               r_sbusy;
  logic [NCKPT-1:0][NREG-1:0][ROB_AW-1:0]   r_stag;

  // commit-cleared views of live and snapshot tables
  logic [NREG-1:0]                          w_cbusy;
  logic [NREG-1:0][ROB_AW-1:0]              w_ctag;
  logic [NCKPT-1:0][NREG-1:0]               w_scbusy;
  logic [NCKPT-1:0][NREG-1:0][ROB_AW-1:0]   w_sctag;
  // selected restore image
  logic [NREG-1:0]                          w_rbusy;
  logic [NREG-1:0][ROB_AW-1:0]              w_rtag;
  // next-state tables
  logic [NREG-1:0]                          w_nbusy;
  logic [NREG-1:0][ROB_AW-1:0]              w_ntag;
  logic [NCKPT-1:0][NREG-1:0]               w_nsbusy;
  logic [NCKPT-1:0][NREG-1:0][ROB_AW-1:0]   w_nstag;

  logic w_cmt_en;
  logic w_iss_en;
  logic w_save_ok;
  logic w_rest_ok;

  // x0 is never written and never renamed.
  assign w_cmt_en  = i_commit && (i_commit_rd != '0);
  assign w_iss_en  = i_issue  && (i_issue_rd  != '0);
  // Slot ids beyond NCKPT only exist for non-power-of-two NCKPT; drop them.
  assign w_save_ok = i_ckpt_save    && (32'(i_ckpt_save_id)    < NCKPT);
  assign w_rest_ok = i_ckpt_restore && (32'(i_ckpt_restore_id) < NCKPT);

  // Read ports, one instance per port.
  for (genvar p = 0; p < NRP; p++) begin : g_rd
    regfile_ckpt_rdport #(
      .DATA_W (DATA_W),
      .NREG   (NREG),
      .REG_AW (REG_AW),
      .ROB_AW (ROB_AW)
    ) u_rd (
      .i_addr       (i_rd_addr[p*REG_AW +: REG_AW]),
      .i_busy       (r_busy),
      .i_tag        (r_tag),
      .i_val        (r_val),
      .i_commit     (i_commit),
      .i_commit_rd  (i_commit_rd),
      .i_commit_val (i_commit_val),
      .i_commit_tag (i_commit_tag),
      .o_busy       (o_rd_busy[p]),
      .o_val        (o_rd_val[p*DATA_W +: DATA_W]),
      .o_tag        (o_rd_tag[p*ROB_AW +: ROB_AW])
    );
  end

  // Live table after the commit clear; only a matching tag retires the producer.
  always_comb begin
    w_cbusy = r_busy;
    w_ctag  = r_tag;
    if (w_cmt_en && r_busy[i_commit_rd] && (r_tag[i_commit_rd] == i_commit_tag)) begin
      w_cbusy[i_commit_rd] = 1'b0;
      w_ctag[i_commit_rd]  = '0;
    end
  end

  // Every snapshot drops the committing tag so a restore never waits on it.
  always_comb begin
    w_scbusy = r_sbusy;
    w_sctag  = r_stag;
    for (int k = 0; k < NCKPT; k++) begin
      if (w_cmt_en && r_sbusy[k][i_commit_rd] &&
          (r_stag[k][i_commit_rd] == i_commit_tag)) begin
        w_scbusy[k][i_commit_rd] = 1'b0;
        w_sctag[k][i_commit_rd]  = '0;
      end
    end
  end

  // Mux out the restore image. A compare loop avoids indexing past NCKPT.
  always_comb begin
    w_rbusy = '0;
    w_rtag  = '0;
    for (int k = 0; k < NCKPT; k++) begin
      if (CKPT_AW'(k) == i_ckpt_restore_id) begin
        w_rbusy = w_scbusy[k];
        w_rtag  = w_sctag[k];
      end
    end
  end

  // Live next state: flush > restore > issue on top of the commit clear.
  always_comb begin
    w_nbusy = w_cbusy;
    w_ntag  = w_ctag;
    if (i_flush_all) begin
      w_nbusy = '0;
      w_ntag  = '0;
    end else if (w_rest_ok) begin
      w_nbusy = w_rbusy;
      w_ntag  = w_rtag;
    end else if (w_iss_en) begin
      w_nbusy[i_issue_rd] = 1'b1;
      w_ntag[i_issue_rd]  = i_issue_tag;
    end
  end

  // Snapshot next state. A save captures the post-commit, post-issue live table.
  always_comb begin
    w_nsbusy = w_scbusy;
    w_nstag  = w_sctag;
    for (int k = 0; k < NCKPT; k++) begin
      if (i_flush_all) begin
        w_nsbusy[k] = '0;
        w_nstag[k]  = '0;
      end else if (!w_rest_ok && w_save_ok && (CKPT_AW'(k) == i_ckpt_save_id)) begin
        w_nsbusy[k] = w_nbusy;
        w_nstag[k]  = w_ntag;
      end
    end
  end

  // State update. rdy low freezes everything; the commit value write is never
  // blocked by flush or restore.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_val   <= '0;
      r_busy  <= '0;
      r_tag   <= '0;
      r_sbusy <= '0;
      r_stag  <= '0;
    end else if (i_rdy) begin
      r_busy  <= w_nbusy;
      r_tag   <= w_ntag;
      r_sbusy <= w_nsbusy;
      r_stag  <= w_nstag;
      if (w_cmt_en) r_val[i_commit_rd] <= i_commit_val;
    end
  end

endmodule

// File: tb/tb_regfile_ckpt.sv
// Directed bench for regfile_ckpt: rename, commit bypass, checkpoint
// save/restore, flush and x0 handling, with hand-computed expectations.
module tb_regfile_ckpt;
  localparam int DATA_W = 32, NREG = 32, REG_AW = 5, ROB_AW = 4;
  localparam int NRP = 2, NCKPT = 4, CKPT_AW = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rdy;
  logic [NRP*REG_AW-1:0] rd_addr;
  logic [NRP-1:0]        rd_busy;
  logic [NRP*DATA_W-1:0] rd_val;
  logic [NRP*ROB_AW-1:0] rd_tag;
  logic                  issue;
  logic [REG_AW-1:0]     issue_rd;
  logic [ROB_AW-1:0]     issue_tag;
  logic                  commit;
  logic [REG_AW-1:0]     commit_rd;
  logic [DATA_W-1:0]     commit_val;
  logic [ROB_AW-1:0]     commit_tag;
  logic                  save;
  logic [CKPT_AW-1:0]    save_id;
  logic                  rest;
  logic [CKPT_AW-1:0]    rest_id;
  logic                  flush;

  int errs = 0;
  int checks = 0;

  regfile_ckpt #(
    .DATA_W(DATA_W), .NREG(NREG), .REG_AW(REG_AW), .ROB_AW(ROB_AW),
    .NRP(NRP), .NCKPT(NCKPT), .CKPT_AW(CKPT_AW)
  ) dut (
    .clk(clk), .rst(rst), .i_rdy(rdy),
    .i_rd_addr(rd_addr), .o_rd_busy(rd_busy), .o_rd_val(rd_val), .o_rd_tag(rd_tag),
    .i_issue(issue), .i_issue_rd(issue_rd), .i_issue_tag(issue_tag),
    .i_commit(commit), .i_commit_rd(commit_rd), .i_commit_val(commit_val),
    .i_commit_tag(commit_tag),
    .i_ckpt_save(save), .i_ckpt_save_id(save_id),
    .i_ckpt_restore(rest), .i_ckpt_restore_id(rest_id),
    .i_flush_all(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // check busy/val/tag of one read port
  task automatic chk_port(input string tag, input int p, input logic eb,
                          input logic [DATA_W-1:0] ev, input logic [ROB_AW-1:0] et);
    chk({tag, ".busy"}, 64'(rd_busy[p]), 64'(eb));
    chk({tag, ".val"},  64'(rd_val[p*DATA_W +: DATA_W]), 64'(ev));
    chk({tag, ".tag"},  64'(rd_tag[p*ROB_AW +: ROB_AW]), 64'(et));
  endtask

  task automatic clr_strobes();
    issue = 0; commit = 0; save = 0; rest = 0; flush = 0;
  endtask

  // advance one clock, then drop strobes
  task automatic tick();
    @(posedge clk); #1;
    clr_strobes();
  endtask

  task automatic rd(input logic [REG_AW-1:0] a0, input logic [REG_AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic do_issue(input logic [REG_AW-1:0] r, input logic [ROB_AW-1:0] t);
    issue = 1; issue_rd = r; issue_tag = t;
  endtask

  task automatic do_commit(input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] v,
                           input logic [ROB_AW-1:0] t);
    commit = 1; commit_rd = r; commit_val = v; commit_tag = t;
  endtask

  initial begin
    rst = 1; rdy = 1; rd_addr = '0;
    issue_rd = '0; issue_tag = '0; commit_rd = '0; commit_val = '0; commit_tag = '0;
    save_id = '0; rest_id = '0;
    clr_strobes();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // reset state: port1 reads x5, port0 reads x0
    rd(5'd0, 5'd5);
    chk_port("rst.p0", 0, 0, 0, 0);
    chk_port("rst.p1", 1, 0, 0, 0);

    // issue x5 tag 3
    do_issue(5, 3); tick();
    rd(5'd5, 5'd0);
    chk_port("iss.x5", 0, 1, 0, 3);

    // commit with matching tag: zero-cycle bypass, then stored free
    do_commit(5, 32'hDEADBEEF, 3); rd(5'd5, 5'd0);
    chk_port("byp.x5", 0, 0, 32'hDEADBEEF, 0);
    tick(); rd(5'd5, 5'd0);
    chk_port("cmt.x5", 0, 0, 32'hDEADBEEF, 0);

    // stale commit (tag mismatch): value written, still busy on newer tag
    do_issue(5, 7); tick();
    do_commit(5, 32'h11, 3); rd(5'd5, 5'd0);
    chk_port("stale.now", 0, 1, 32'hDEADBEEF, 7);
    tick(); rd(5'd5, 5'd0);
    chk_port("stale.nxt", 0, 1, 32'h11, 7);

    // snapshot slot1 sees the commit of the tag it waited on
    do_issue(6, 2); tick();
    save = 1; save_id = 1; tick();
    do_issue(6, 9); tick();
    do_commit(6, 32'h55, 2); tick();
    rd(5'd6, 5'd5);
    chk_port("x6.live", 0, 1, 32'h55, 9);
    rest = 1; rest_id = 1; tick();
    rd(5'd6, 5'd5);
    chk_port("rst1.x6", 0, 0, 32'h55, 0);
    chk_port("rst1.x5", 1, 1, 32'h11, 7);

    // save in the same cycle as an issue captures that issue
    do_issue(7, 4); save = 1; save_id = 0; tick();
    do_issue(8, 5); tick();
    rd(5'd8, 5'd7);
    chk_port("x8.live", 0, 1, 0, 5);
    rest = 1; rest_id = 0; tick();
    rd(5'd7, 5'd8);
    chk_port("rst0.x7", 0, 1, 0, 4);
    chk_port("rst0.x8", 1, 0, 0, 0);

    // flush beats restore and issue; commit value still written
    do_issue(10, 6); tick();
    save = 1; save_id = 2; tick();
    flush = 1; rest = 1; rest_id = 2; do_issue(9, 1); do_commit(3, 32'h77, 0); tick();
    rd(5'd3, 5'd9);
    chk_port("fl.x3", 0, 0, 32'h77, 0);
    chk_port("fl.x9", 1, 0, 0, 0);
    rd(5'd10, 5'd5);
    chk_port("fl.x10", 0, 0, 0, 0);
    chk_port("fl.x5", 1, 0, 32'h11, 0);
    rest = 1; rest_id = 2; tick();
    rd(5'd10, 5'd7);
    chk_port("fl.snap.x10", 0, 0, 0, 0);
    chk_port("fl.snap.x7", 1, 0, 0, 0);

    // x0 is never renamed nor written
    do_issue(0, 5); do_commit(0, 32'h123, 5); tick();
    rd(5'd0, 5'd0);
    chk_port("x0", 0, 0, 0, 0);

    // rdy low holds all state
    rdy = 0; do_issue(11, 2); do_commit(11, 32'hAB, 0); tick();
    rdy = 1; rd(5'd11, 5'd0);
    chk_port("rdy0.x11", 0, 0, 0, 0);

    // restore applies a same-cycle commit clear; same-cycle issue is dropped
    do_issue(12, 8); tick();
    save = 1; save_id = 3; tick();
    do_issue(12, 9); tick();
    rest = 1; rest_id = 3; do_commit(12, 32'h99, 8); do_issue(13, 1); tick();
    rd(5'd12, 5'd13);
    chk_port("rc.x12", 0, 0, 32'h99, 0);
    chk_port("rc.x13", 1, 0, 0, 0);

    // issue overrides a same-cycle commit clear on the same register
    do_issue(5, 7); tick();
    do_commit(5, 32'h42, 7); do_issue(5, 4); rd(5'd5, 5'd0);
    chk_port("ovr.byp", 0, 0, 32'h42, 0);
    tick(); rd(5'd5, 5'd0);
    chk_port("ovr.nxt", 0, 1, 32'h42, 4);

    // same-cycle issue is not visible to reads
    do_issue(13, 1); rd(5'd0, 5'd13);
    chk_port("iss.hid", 1, 0, 0, 0);
    tick(); rd(5'd0, 5'd13);
    chk_port("iss.vis", 1, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/regfile_ckpt.md
Name: regfile_ckpt

Overview:
Parametrised architectural register file with rename-status table for the Tomasulo/RoB core: NRP combinational read ports, one issue (rename) port and one commit port. It adds NCKPT branch checkpoints of the busy/tag table, so a mispredict can restore rename state in one cycle instead of flushing everything. It sits between Decoder (reads, issue, checkpoint save) and RoB (commit, restore, full flush).

Parameters:
DATA_W  32  register data width
NREG  32  number of architectural registers; register 0 is hardwired zero
REG_AW  5  register address width, clog2(NREG)
ROB_AW  4  RoB tag width
NRP  2  number of read ports
NCKPT  4  number of checkpoint slots
CKPT_AW  2  checkpoint id width, clog2(NCKPT)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rdy  in  1  global enable; when low, no state changes
rd_addr  in  NRP*REG_AW  read addresses; port p is at [p*REG_AW +: REG_AW]
rd_busy  out  NRP  port p: register awaits a RoB result
rd_val  out  NRP*DATA_W  port p: register value
rd_tag  out  NRP*ROB_AW  port p: producing RoB tag, valid when busy
issue  in  1  rename issue_rd to issue_tag
issue_rd  in  REG_AW  destination register of the issued instruction
issue_tag  in  ROB_AW  RoB position of the issued instruction
commit  in  1  RoB commit strobe
commit_rd  in  REG_AW  committed destination register
commit_val  in  DATA_W  committed value
commit_tag  in  ROB_AW  RoB position of the committing entry
ckpt_save  in  1  snapshot the busy/tag table into slot ckpt_save_id
ckpt_save_id  in  CKPT_AW  slot to save into
ckpt_restore  in  1  reload the busy/tag table from slot ckpt_restore_id
ckpt_restore_id  in  CKPT_AW  slot to restore from
flush_all  in  1  full rollback: clear all rename state

Behaviour:
- State: val[NREG], live busy/tag[NREG], and snapshot busy/tag[NCKPT][NREG].
- Reset: all vals 0; all busy 0; all tags 0, in both live and snapshot tables. After reset, every read port returns busy 0, val 0, tag 0.
- rdy low: all state is held. Reads stay combinational.
- Reads (combinational, per port):
  - rd_addr = 0: busy 0, val 0, tag 0.
  - Commit bypass: if commit, commit_rd != 0, rd_addr == commit_rd, live busy[commit_rd] = 1 and live tag == commit_tag, then the port returns busy 0, val commit_val, tag 0.
  - Otherwise the port returns the stored busy, val and tag.
  - A same-cycle issue is not visible to reads; reads see pre-issue state.
- Commit (rd != 0), applied first within the cycle:
  - val[commit_rd] <= commit_val unconditionally.
  - If live busy and live tag == commit_tag: live busy 0, tag 0.
  - In every snapshot slot where busy[commit_rd] = 1 and tag == commit_tag: clear busy and tag. This keeps snapshots from waiting on already-committed tags.
- Issue (issue_rd != 0): live busy[issue_rd] <= 1, tag <= issue_tag. Issue overrides a same-cycle commit clear on the same register.
- Save: snapshot[ckpt_save_id] <= next-state of the live table, i.e. after this cycle's commit and issue.
  - Save into a slot also hit by a same-cycle commit: the saved image already has the commit clear applied.
- Restore: live busy/tag <= snapshot[ckpt_restore_id], with the same-cycle commit tag-match clear applied.
  - Same-cycle issue and save are ignored.
  - val is not affected except by the commit write.
- flush_all: live and all snapshot busy/tag cleared to 0. Issue, save and restore are ignored; the commit val write still occurs.
- Priority: flush_all > ckpt_restore > (issue, ckpt_save).
- Out-of-range ids (>= NCKPT when NCKPT is not a power of 2): save and restore are ignored.
- Register 0: never written, never busy, in either the live or the snapshot tables.
- Latency: all updates are visible on reads in the cycle after the clock edge. Commit forwarding is zero-cycle.

Test Plan:
- Reset, then drive rd_addr = {5, 0} -> both ports return busy 0, val 0, tag 0. Issue x5 with tag 3; next cycle port0 returns busy 1, tag 3.
- x5 busy with tag 3; commit rd = 5, val 0xDEADBEEF, tag 3 while reading x5 -> same cycle busy 0, val 0xDEADBEEF; next cycle stored busy 0.
- x5 busy with tag 7; commit rd = 5, tag 3, val 0x11 -> port shows busy 1, tag 7; next cycle val = 0x11 and still busy with tag 7.
- Issue x6 tag 2; save slot 1; issue x6 tag 9; commit x6 tag 2 val 0x55; restore slot 1 -> x6 busy 0, val 0x55.
- Issue x7 tag 4 with save slot 0 in the same cycle; issue x8 tag 5; restore slot 0 -> x7 busy with tag 4, x8 busy 0.
- Same cycle: flush_all, restore slot 2, issue x9 tag 1, commit x3 val 0x77 -> all busy 0, val[3] = 0x77, x9 not busy. Separately, issue x0 -> x0 reads busy 0, val 0.
